// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg: shared encodings for the data-memory access controller.
//   - access size encodings (dm_size_e)
//   - memory byte-enable patterns
//   - request payload struct and a packing helper
// -----------------------------------------------------------------------------
package dm_pkg;

    localparam int unsigned DM_WORD_ADDR_W = 11;
    localparam int unsigned DM_DATA_W      = 32;
    localparam int unsigned DM_BE_W        = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } dm_size_e;

    // The only enable patterns the memory macro supports
    localparam logic [DM_BE_W-1:0] BE_NONE = 4'b0000;
    localparam logic [DM_BE_W-1:0] BE_B0   = 4'b0001;
    localparam logic [DM_BE_W-1:0] BE_B1   = 4'b0010;
    localparam logic [DM_BE_W-1:0] BE_B2   = 4'b0100;
    localparam logic [DM_BE_W-1:0] BE_B3   = 4'b1000;
    localparam logic [DM_BE_W-1:0] BE_H0   = 4'b0011;
    localparam logic [DM_BE_W-1:0] BE_H1   = 4'b1100;
    localparam logic [DM_BE_W-1:0] BE_WORD = 4'b1111;

    typedef struct packed {
        logic                 we;
        dm_size_e             size;
        logic                 sgn;
        logic [DM_DATA_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
    } dm_req_t;

    // Bundle one requester's raw port signals into a request payload
    function automatic dm_req_t dm_pack_req(
        input logic                 we,
        input logic [1:0]           size,
        input logic                 sgn,
        input logic [DM_DATA_W-1:0] addr,
        input logic [DM_DATA_W-1:0] wdata
    );
        dm_req_t r;
        r.we    = we;
        r.size  = dm_size_e'(size);
        r.sgn   = sgn;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// -----------------------------------------------------------------------------
// dm_lane_fmt: combinational lane logic for one memory access.
//   i_size   : access size
//   i_addr   : full byte address
//   i_signed : sign-extend loads (ignored for word)
//   i_rd     : memory read word
//   o_be     : store byte-enable pattern (BE_NONE on error)
//   o_err    : misaligned, illegal size or out-of-range address
//   o_rdata  : extracted and extended load data
// -----------------------------------------------------------------------------
module dm_lane_fmt
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 13
) (
    input  dm_size_e               i_size,
    input  logic [DM_DATA_W-1:0]   i_addr,
    input  logic                   i_signed,
    input  logic [DM_DATA_W-1:0]   i_rd,
    output logic [DM_BE_W-1:0]     o_be,
    output logic                   o_err,
    output logic [DM_DATA_W-1:0]   o_rdata
);

    logic [1:0]  w_off;
    logic        w_bad_align;
    logic        w_out_of_range;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [DM_BE_W-1:0] w_be_raw;

    assign w_off          = i_addr[1:0];
    assign w_out_of_range = (i_addr >> ADDR_BITS) != '0;

    // Enable pattern and alignment check by size/offset
    always_comb begin
        w_be_raw    = BE_NONE;
        w_bad_align = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                case (w_off)
                    2'd0:    w_be_raw = BE_B0;
                    2'd1:    w_be_raw = BE_B1;
                    2'd2:    w_be_raw = BE_B2;
                    default: w_be_raw = BE_B3;
                endcase
            end
            SZ_HALF: begin
                if (w_off[0]) w_bad_align = 1'b1;
                else          w_be_raw    = w_off[1] ? BE_H1 : BE_H0;
            end
            SZ_WORD: begin
                if (w_off != 2'd0) w_bad_align = 1'b1;
                else               w_be_raw    = BE_WORD;
            end
            default: w_bad_align = 1'b1;
        endcase
    end

    assign o_err = w_bad_align | w_out_of_range;
    assign o_be  = o_err ? BE_NONE : w_be_raw;

    // Lane select for loads
    assign w_byte = i_rd[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? i_rd[31:16] : i_rd[15:0];

    always_comb begin
        o_rdata = '0;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            SZ_WORD: o_rdata = i_rd;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter: two-port round-robin access controller for the data memory.
//   clk, rst                 : clock, synchronous active-high reset
//   m0_* / m1_*              : MEM-stage / debug request ports (valid/ready,
//                              we, size, signed, addr, wdata)
//   rsp_valid/port/data/err  : registered one-cycle response per accept
//   err_cnt                  : saturating count of error responses
//   dm_addr/dm_wd/dm_be      : memory word address, write data, byte enables
//   dm_rd                    : asynchronous memory read data
// -----------------------------------------------------------------------------
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 13,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_valid,
    output logic                      m0_ready,
    input  logic                      m0_we,
    input  logic [1:0]                m0_size,
    input  logic                      m0_signed,
    input  logic [DM_DATA_W-1:0]      m0_addr,
    input  logic [DM_DATA_W-1:0]      m0_wdata,
    input  logic                      m1_valid,
    output logic                      m1_ready,
    input  logic                      m1_we,
    input  logic [1:0]                m1_size,
    input  logic                      m1_signed,
    input  logic [DM_DATA_W-1:0]      m1_addr,
    input  logic [DM_DATA_W-1:0]      m1_wdata,
    output logic                      rsp_valid,
    output logic                      rsp_port,
    output logic [DM_DATA_W-1:0]      rsp_data,
    output logic                      rsp_err,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output logic [DM_WORD_ADDR_W-1:0] dm_addr,
    output logic [DM_DATA_W-1:0]      dm_wd,
    output logic [DM_BE_W-1:0]        dm_be,
    input  logic [DM_DATA_W-1:0]      dm_rd
);

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic                 w_sel;
    dm_req_t              w_req;
    logic [DM_BE_W-1:0]   w_be;
    logic                 w_err;
    logic [DM_DATA_W-1:0] w_load_data;

    logic                 r_last_grant;
    logic                 r_rsp_valid;
    logic                 r_rsp_port;
    logic [DM_DATA_W-1:0] r_rsp_data;
    logic                 r_rsp_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Round-robin grant: on a tie, the port that did not win last time
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!rst) begin
            w_grant0 = m0_valid & (~m1_valid | r_last_grant);
            w_grant1 = m1_valid & (~m0_valid | ~r_last_grant);
        end
    end

    assign w_accept = w_grant0 | w_grant1;
    assign w_sel    = w_grant1;
    assign m0_ready = w_grant0;
    assign m1_ready = w_grant1;

    // Granted request payload; port 0 fields when nothing is granted
    always_comb begin
        w_req = dm_pack_req(m0_we, m0_size, m0_signed, m0_addr, m0_wdata);
        if (w_sel) begin
            w_req = dm_pack_req(m1_we, m1_size, m1_signed, m1_addr, m1_wdata);
        end
    end

    dm_lane_fmt #(
        .ADDR_BITS (ADDR_BITS)
    ) u_lane_fmt (
        .i_size   (w_req.size),
        .i_addr   (w_req.addr),
        .i_signed (w_req.sgn),
        .i_rd     (dm_rd),
        .o_be     (w_be),
        .o_err    (w_err),
        .o_rdata  (w_load_data)
    );

    // Memory side: wdata stays right-aligned, the macro steers it into lanes
    assign dm_addr = w_req.addr[2 +: DM_WORD_ADDR_W];
    assign dm_wd   = w_req.wdata;
    assign dm_be   = (w_accept && w_req.we) ? w_be : BE_NONE;

    // Grant history, response stage and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_port   <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_last_grant <= w_sel;
                r_rsp_port   <= w_sel;
                r_rsp_err    <= w_err;
                r_rsp_data   <= (w_err || w_req.we) ? '0 : w_load_data;
                if (w_err && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_port  = r_rsp_port;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural memory that
// steers right-aligned write data into the enabled lanes.
// -----------------------------------------------------------------------------
module tb_dm_arbiter;
    import dm_pkg::*;

    logic        clk;
    logic        rst;
    logic        m0_valid, m0_ready, m0_we, m0_signed;
    logic [1:0]  m0_size;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_valid, m1_ready, m1_we, m1_signed;
    logic [1:0]  m1_size;
    logic [31:0] m1_addr, m1_wdata;
    logic        rsp_valid, rsp_port, rsp_err;
    logic [31:0] rsp_data;
    logic [15:0] err_cnt;
    logic [10:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_rd;

    logic [31:0] tb_mem [0:2047];

    int n_cmp = 0;
    int n_err = 0;

    dm_arbiter #(.ADDR_BITS(13), .ERR_CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_we     (m0_we),
        .m0_size   (m0_size),
        .m0_signed (m0_signed),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_we     (m1_we),
        .m1_size   (m1_size),
        .m1_signed (m1_signed),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .rsp_valid (rsp_valid),
        .rsp_port  (rsp_port),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt),
        .dm_addr   (dm_addr),
        .dm_wd     (dm_wd),
        .dm_be     (dm_be),
        .dm_rd     (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preset to 0x1000_0000+index during reset
    assign dm_rd = tb_mem[dm_addr];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) tb_mem[i] <= 32'h1000_0000 + 32'(i);
        end else begin
            case (dm_be)
                4'b0001: tb_mem[dm_addr][7:0]   <= dm_wd[7:0];
                4'b0010: tb_mem[dm_addr][15:8]  <= dm_wd[7:0];
                4'b0100: tb_mem[dm_addr][23:16] <= dm_wd[7:0];
                4'b1000: tb_mem[dm_addr][31:24] <= dm_wd[7:0];
                4'b0011: tb_mem[dm_addr][15:0]  <= dm_wd[15:0];
                4'b1100: tb_mem[dm_addr][31:16] <= dm_wd[15:0];
                4'b1111: tb_mem[dm_addr]        <= dm_wd;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_valid = 1'b0;
        m1_valid = 1'b0;
    endtask

    // Present one request on port p, the other port idle
    task automatic drive(input logic p, input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] wd);
        m0_valid = ~p;
        m1_valid = p;
        if (!p) begin
            m0_we = we; m0_size = sz; m0_signed = sg; m0_addr = a; m0_wdata = wd;
        end else begin
            m1_we = we; m1_size = sz; m1_signed = sg; m1_addr = a; m1_wdata = wd;
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_valid = 0; m0_we = 0; m0_size = 0; m0_signed = 0; m0_addr = 0; m0_wdata = 0;
        m1_valid = 0; m1_we = 0; m1_size = 0; m1_signed = 0; m1_addr = 0; m1_wdata = 0;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_port",  32'(rsp_port),  32'd0);
        chk("rst_rsp_data",  rsp_data,       32'd0);
        chk("rst_rsp_err",   32'(rsp_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst = 1'b0;

        // sw 0xDEADBEEF @0x10 from port 0
        drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
        #1;
        chk("sw_m0_ready", 32'(m0_ready), 32'd1);
        chk("sw_m1_ready", 32'(m1_ready), 32'd0);
        chk("sw_dm_addr",  32'(dm_addr),  32'd4);
        chk("sw_dm_be",    32'(dm_be),    32'hF);
        chk("sw_dm_wd",    dm_wd,         32'hDEAD_BEEF);
        tick();
        idle();
        chk("sw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("sw_rsp_port",  32'(rsp_port),  32'd0);
        chk("sw_rsp_err",   32'(rsp_err),   32'd0);
        chk("sw_rsp_data",  rsp_data,       32'd0);
        chk("sw_mem4",      tb_mem[4],      32'hDEAD_BEEF);
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // signed lb @0x13 from port 1
        drive(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0);
        #1;
        chk("lb_m1_ready", 32'(m1_ready), 32'd1);
        chk("lb_dm_be",    32'(dm_be),    32'h0);
        tick();
        chk("lb_rsp_data", rsp_data,       32'hFFFF_FFDE);
        chk("lb_rsp_port", 32'(rsp_port), 32'd1);

        // unsigned lh @0x12, port 0 (back to back)
        drive(1'b0, 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0);
        tick();
        chk("lhu_rsp_data", rsp_data, 32'h0000_DEAD);
        chk("lhu_rsp_port", 32'(rsp_port), 32'd0);

        // signed lh @0x10, port 1
        drive(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0);
        tick();
        chk("lh_rsp_data", rsp_data, 32'hFFFF_BEEF);

        // unsigned lb @0x12, port 0
        drive(1'b0, 1'b0, SZ_BYTE, 1'b0, 32'h12, 32'h0);
        tick();
        chk("lbu_rsp_data", rsp_data, 32'h0000_00AD);

        // sb 0x55 @0x11 then lw @0x10 in the very next cycle
        drive(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FF55);
        #1;
        chk("sb_dm_be", 32'(dm_be), 32'b0010);
        chk("sb_dm_wd", dm_wd,      32'hFFFF_FF55);
        tick();
        chk("sb_rsp_valid", 32'(rsp_valid), 32'd1);
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        tick();
        chk("lw_after_sb_data",  rsp_data,        32'hDEAD_55EF);
        chk("lw_after_sb_valid", 32'(rsp_valid), 32'd1);
        chk("lw_after_sb_port",  32'(rsp_port),  32'd1);

        // sh 0xCAFE @0x16
        drive(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h0000_CAFE);
        #1;
        chk("sh_dm_be",   32'(dm_be),   32'b1100);
        chk("sh_dm_addr", 32'(dm_addr), 32'd5);
        tick();
        idle();
        tick();
        chk("sh_mem5", tb_mem[5], 32'hCAFE_0005);

        // Error cases
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0);
        #1;
        chk("err_lw_dm_be", 32'(dm_be), 32'h0);
        tick();
        chk("err_lw_rsp_err",  32'(rsp_err), 32'd1);
        chk("err_lw_rsp_data", rsp_data,      32'd0);
        chk("err_lw_cnt",      32'(err_cnt), 32'd1);
        drive(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h2000, 32'h1111_1111);
        #1;
        chk("err_sw_m0_ready", 32'(m0_ready), 32'd1);
        chk("err_sw_dm_be",    32'(dm_be),    32'h0);
        tick();
        chk("err_sw_rsp_err", 32'(rsp_err), 32'd1);
        chk("err_sw_cnt",     32'(err_cnt), 32'd2);
        chk("err_sw_mem0",    tb_mem[0],    32'h1000_0000);
        drive(1'b1, 1'b1, SZ_HALF, 1'b1, 32'h11, 32'h0000_7777);
        #1;
        chk("err_sh_dm_be", 32'(dm_be), 32'h0);
        tick();
        chk("err_sh_rsp_err", 32'(rsp_err), 32'd1);
        drive(1'b0, 1'b0, SZ_ILL, 1'b0, 32'h10, 32'h0);
        tick();
        chk("err_sz_rsp_err",  32'(rsp_err), 32'd1);
        chk("err_sz_rsp_data", rsp_data,      32'd0);
        chk("err_sz_cnt",      32'(err_cnt), 32'd4);
        chk("err_mem4",        tb_mem[4],    32'hDEAD_55EF);

        // Pending load response, then reset with both ports requesting stores
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        tick();
        rst = 1'b1;
        m0_valid = 1'b1; m0_we = 1'b1; m0_size = SZ_WORD; m0_addr = 32'h20; m0_wdata = 32'hAAAA_0000;
        m1_valid = 1'b1; m1_we = 1'b1; m1_size = SZ_WORD; m1_addr = 32'h24; m1_wdata = 32'hBBBB_1111;
        #1;
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_dm_be",    32'(dm_be),    32'h0);
        tick();
        chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err_clr",    32'(err_cnt),   32'd0);
        chk("rst2_m0_ready",  32'(m0_ready),  32'd0);
        tick();
        rst = 1'b0;
        #1;

        // Tie for four cycles: 0,1,0,1
        chk("rr0_m0_ready", 32'(m0_ready), 32'd1);
        chk("rr0_m1_ready", 32'(m1_ready), 32'd0);
        chk("rr0_dm_addr",  32'(dm_addr),  32'd8);
        tick();
        chk("rr1_m0_ready", 32'(m0_ready), 32'd0);
        chk("rr1_m1_ready", 32'(m1_ready), 32'd1);
        chk("rr1_dm_addr",  32'(dm_addr),  32'd9);
        chk("rr0_rsp_port", 32'(rsp_port), 32'd0);
        tick();
        chk("rr2_m0_ready", 32'(m0_ready), 32'd1);
        chk("rr2_m1_ready", 32'(m1_ready), 32'd0);
        chk("rr1_rsp_port", 32'(rsp_port), 32'd1);
        tick();
        chk("rr3_m0_ready", 32'(m0_ready), 32'd0);
        chk("rr3_m1_ready", 32'(m1_ready), 32'd1);
        chk("rr2_rsp_port", 32'(rsp_port), 32'd0);
        tick();
        idle();
        chk("rr3_rsp_port",  32'(rsp_port),  32'd1);
        chk("rr3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rr_mem8",       tb_mem[8],      32'hAAAA_0000);
        chk("rr_mem9",       tb_mem[9],      32'hBBBB_1111);
        tick();
        chk("end_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port access controller for the single-ported data memory. It arbitrates round-robin between the pipeline MEM stage (port 0) and the debug/loader port (port 1), and turns byte-addressed sized loads and stores into word address plus byte-enable accesses. Each accepted request gets one registered, sign/zero-extended response. It sits between the MEM stage and the data memory instance and is the only driver of that memory's address, write-data and byte-enable inputs.

## Interface
- `ADDR_BITS`, 13: byte-address width backed by memory; higher address bits must be zero.
- `ERR_CNT_W`, 16: width of the saturating error counter.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `m0_valid`, `m1_valid` in 1: request present; held stable until accepted.
- `m0_ready`, `m1_ready` out 1: request accepted at this clock edge.
- `m0_we`, `m1_we` in 1: 1 is store, 0 is load.
- `m0_size`, `m1_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `m0_signed`, `m1_signed` in 1: sign-extend loads.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response valid for one cycle.
- `rsp_port` out 1: requester of this response.
- `rsp_data` out 32: formatted load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned, illegal size or out-of-range access.
- `err_cnt` out `ERR_CNT_W`: saturating count of error responses.
- `dm_addr` out 11: word address, equal to byte addr[12:2].
- `dm_wd` out 32: memory write data.
- `dm_be` out 4: memory byte enables; 0000 means no write.
- `dm_rd` in 32: asynchronous memory read data for `dm_addr`.

## Operation
- Arbitration is combinational in the issue cycle.
  - One valid port: that port is granted.
  - Both valid: the port other than `last_grant` is granted.
  - `last_grant` updates on each accept. It resets to 1, so port 0 wins the first tie.
  - `mX_ready` equals grant for that port, and is forced to 0 while `rst` is high.
- The granted request drives `dm_addr` from addr[12:2]. `dm_wd` carries the granted `wdata` unshifted, because the memory places wd[7:0] or wd[15:0] into the enabled lanes. The memory only supports the enable patterns listed below.
- Store byte enables, chosen by size and addr[1:0]:
  - byte: offset 0/1/2/3 gives 0001/0010/0100/1000.
  - half: offset 0 gives 0011, offset 2 gives 1100.
  - word: offset 0 gives 1111.
- `dm_be` is 0000 when there is no grant, for loads, on any error, and during `rst`.
- Error conditions, all of which set `rsp_err`:
  - half access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - size 11;
  - addr[31:ADDR_BITS]≠0.
- An erroring request is still accepted and answered, with no memory write and `rsp_data`=0.
- Load formatting uses `dm_rd` sampled at the accept edge:
  - Select the byte or half lane by offset.
  - Zero-extend, or sign-extend when `signed` is 1. `signed` is ignored for word loads.
- `err_cnt` increments on each error accept and saturates at all-ones.

## Timing
- Throughput is one access per cycle. Back-to-back accepts from either port are allowed.
- A store writes memory at the accept edge.
- The response appears in the cycle after accept, via registered `rsp_valid`, `rsp_port`, `rsp_data` and `rsp_err`. `rsp_valid` is high for exactly one cycle per accept and low otherwise.
- Responses return in request order. No backpressure on responses; requesters must consume them.
- A load accepted in the cycle after a store to the same word returns the new data.
- Reset values: `rsp_valid`=0, `rsp_port`=0, `rsp_data`=0, `rsp_err`=0, `err_cnt`=0, `last_grant`=1.
- While `rst` is high: no accepts and no writes. A response pending from the previous accept is dropped.
- There is no FSM beyond the `last_grant` and response registers. Treat the response stage as a 1-deep pipeline register.

## Structure
- Package `dm_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - byte-enable constants;
  - `DM_WORD_ADDR_W`=11.
- Sub-module `dm_lane_fmt` (combinational): computes store `be` and error from size/offset/addr, and computes load extract/extend from `rd`/size/offset/signed. It is instantiated once for the granted request.

## Test plan
- Port 0 stores word 0xDEADBEEF at 0x10 → `dm_addr`=4 and `dm_be`=1111 in that cycle; next cycle `rsp_valid`=1, `rsp_port`=0, `rsp_err`=0.
- Signed lb from 0x13 → `rsp_data`=0xFFFFFFDE; unsigned lh from 0x12 → 0x0000DEAD; signed lh from 0x10 → 0xFFFFBEEF.
- sb 0x55 at 0x11 → `dm_be`=0010; a following lw from 0x10 returns 0xDEAD55EF.
- Both ports valid for 4 cycles after reset → grants go 0,1,0,1; each port's `ready` pulses on its grant cycle only.
- lw from 0x02 and sw to 0x2000 → `rsp_err`=1 on both, `dm_be`=0000, memory unchanged, `err_cnt`=2.
- `rst` high for 2 cycles with both ports valid → both readys 0, `dm_be`=0000, `rsp_valid`=0, `err_cnt` cleared; on release, port 0 is granted first.
